// File: rtl/share_mem_pkg.sv
// Address map, FSM state encoding and owner encoding for the shared-memory arbiter.
// Pure constants and a range helper; no logic, no latency.
// Nothing here applies backpressure.
package share_mem_pkg;

  // Word addresses seen by both CPUs
  localparam logic [21:0] CPUA_MEM_BEGIN   = 22'h00_2000;
  localparam logic [21:0] CPUA_MEM_END     = 22'h00_21FF;
  localparam logic [21:0] CPUB_MEM_BEGIN   = 22'h00_2200;
  localparam logic [21:0] CPUB_MEM_END     = 22'h00_23FF;
  localparam logic [21:0] SWITCH_BOARD_MEM = 22'h00_2400;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Owner encoding
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // Inclusive address range test
  function automatic logic addr_in(input logic [21:0] addr,
                                   input logic [21:0] lo,
                                   input logic [21:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/share_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the winner is combinational from the requests.
// last_winner updates on the clock edge where the grant strobe is high.
// No backpressure of its own; the caller decides when a grant is taken.
module rr_arb2
  import share_mem_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_grant_en,
  output logic o_winner
);

  logic r_last_winner;

  // On a tie the requester that did not win last time goes first
  assign o_winner = (i_req_a && i_req_b) ? ~r_last_winner :
                    (i_req_b ? OWNER_B : OWNER_A);

  // Remember who was granted; starts at B so that A wins the first tie
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_winner <= OWNER_B;
    end else if (i_grant_en) begin
      r_last_winner <= o_winner;
    end
  end

endmodule

// File: rtl/share_mem_arbiter.sv
// Shares a single-port 1Kx32 memory between CPU A and B with per-CPU write windows.
// Latency: grant in IDLE, memory strobe +1, capture +2, one-cycle ack +3; one access per 4 cycles.
// Backpressure: a req is held until its ack; the losing or late requester waits in IDLE.
module share_mem_arbiter
  import share_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        A_req,
  input  logic        B_req,
  input  logic        A_we,
  input  logic        B_we,
  input  logic [21:0] A_addr,
  input  logic [21:0] B_addr,
  input  logic [31:0] A_write_data,
  input  logic [31:0] B_write_data,
  output logic        A_ack,
  output logic        B_ack,
  output logic        A_err,
  output logic        B_err,
  output logic [31:0] A_read_data,
  output logic [31:0] B_read_data,
  output logic [15:0] A_viol_cnt,
  output logic [15:0] B_viol_cnt,
  input  logic [31:0] sw_info,
  output logic        mem_en,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic [1:0]  r_state;
  logic        r_owner;
  logic        r_we;
  logic        r_err;
  logic [21:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_a_rdata;
  logic [31:0] r_b_rdata;
  logic [15:0] r_a_viol;
  logic [15:0] r_b_viol;

  logic        w_grant;
  logic        w_winner;
  logic        w_is_mem;
  logic        w_is_swb;
  logic        w_in_window;
  logic        w_mem_ok;
  logic        w_err;
  logic [31:0] w_cap_data;

  assign w_grant = (r_state == ST_IDLE) && (A_req || B_req);

  rr_arb2 u_arb (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_a    (A_req),
    .i_req_b    (B_req),
    .i_grant_en (w_grant),
    .o_winner   (w_winner)
  );

  // Classification works on the latched request only, so outputs never see req directly
  assign w_is_mem    = addr_in(r_addr, CPUA_MEM_BEGIN, CPUB_MEM_END);
  assign w_is_swb    = (r_addr == SWITCH_BOARD_MEM);
  assign w_in_window = (r_owner == OWNER_A) ? addr_in(r_addr, CPUA_MEM_BEGIN, CPUA_MEM_END)
                                            : addr_in(r_addr, CPUB_MEM_BEGIN, CPUB_MEM_END);
  assign w_mem_ok    = w_is_mem && (!r_we || w_in_window);
  assign w_err       = !(w_mem_ok || (w_is_swb && !r_we));

  // Read data to capture: memory, switch-board word, or zero for writes and bad addresses
  always_comb begin
    w_cap_data = 32'd0;
    if (!r_we && w_is_mem) begin
      w_cap_data = mem_rdata;
    end else if (!r_we && w_is_swb) begin
      w_cap_data = sw_info;
    end
  end

  // Sequence IDLE -> ACCESS -> CAPTURE -> DONE and latch the winning request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWNER_A;
      r_we    <= 1'b0;
      r_addr  <= 22'd0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_owner <= w_winner;
            r_we    <= (w_winner == OWNER_B) ? B_we : A_we;
            r_addr  <= (w_winner == OWNER_B) ? B_addr : A_addr;
            r_wdata <= (w_winner == OWNER_B) ? B_write_data : A_write_data;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS:  r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          r_err   <= w_err;
          r_state <= ST_DONE;
        end
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Load the owner's read-data register in CAPTURE; it holds until that port's next access
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_rdata <= 32'd0;
      r_b_rdata <= 32'd0;
    end else if (r_state == ST_CAPTURE) begin
      if (r_owner == OWNER_A) begin
        r_a_rdata <= w_cap_data;
      end else begin
        r_b_rdata <= w_cap_data;
      end
    end
  end

  // Count rejected accesses per CPU as they are acknowledged, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_viol <= 16'd0;
      r_b_viol <= 16'd0;
    end else if ((r_state == ST_DONE) && r_err) begin
      if (r_owner == OWNER_A) begin
        if (r_a_viol != 16'hFFFF) r_a_viol <= r_a_viol + 16'd1;
      end else begin
        if (r_b_viol != 16'hFFFF) r_b_viol <= r_b_viol + 16'd1;
      end
    end
  end

  assign A_ack       = (r_state == ST_DONE) && (r_owner == OWNER_A);
  assign B_ack       = (r_state == ST_DONE) && (r_owner == OWNER_B);
  assign A_err       = A_ack && r_err;
  assign B_err       = B_ack && r_err;
  assign A_read_data = r_a_rdata;
  assign B_read_data = r_b_rdata;
  assign A_viol_cnt  = r_a_viol;
  assign B_viol_cnt  = r_b_viol;
  assign mem_en      = (r_state == ST_ACCESS) && w_mem_ok;
  assign mem_we      = (r_state == ST_ACCESS) && w_mem_ok && r_we;
  assign mem_addr    = r_addr[9:0];
  assign mem_wdata   = r_wdata;

endmodule

// File: tb/tb_share_mem_arbiter.sv
// Bench for share_mem_arbiter: directed vector table, reset/tie/saturation sequences,
// then randomized two-CPU traffic checked against a rule-level model of the address map.
// Inputs are driven and outputs sampled on the falling edge.
module tb_share_mem_arbiter;

  typedef struct {
    bit          p;
    bit          we;
    logic [21:0] a;
    logic [31:0] wd;
    logic [31:0] sw;
    bit          e_err;
    logic [31:0] e_rd;
    bit          e_en;
    bit          e_we;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_v [2];
  logic        we_v [2];
  logic [21:0] addr_v [2];
  logic [31:0] wd_v [2];
  logic        ack_v [2];
  logic        err_v [2];
  logic [31:0] rd_v [2];
  logic [15:0] viol_v [2];
  logic [31:0] sw_info;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  share_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .A_req(req_v[0]), .B_req(req_v[1]),
    .A_we(we_v[0]), .B_we(we_v[1]),
    .A_addr(addr_v[0]), .B_addr(addr_v[1]),
    .A_write_data(wd_v[0]), .B_write_data(wd_v[1]),
    .A_ack(ack_v[0]), .B_ack(ack_v[1]),
    .A_err(err_v[0]), .B_err(err_v[1]),
    .A_read_data(rd_v[0]), .B_read_data(rd_v[1]),
    .A_viol_cnt(viol_v[0]), .B_viol_cnt(viol_v[1]),
    .sw_info(sw_info),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_pat(input int i);
    if (i == 5) return 32'h1234_5678;
    return (32'(i) * 32'h0001_0101) ^ 32'h5000_0000;
  endfunction

  // External single-port memory with synchronous read
  logic [31:0] mem_arr [1024];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= init_pat(i);
    end else if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [1024];
  logic [31:0] exp_rd [2];
  logic [15:0] exp_viol [2];
  int          model_last;
  bit          pend [2];
  int          craise [2];
  logic [21:0] edge_addr [6] = '{22'h1FFF, 22'h2000, 22'h21FF, 22'h2200, 22'h23FF, 22'h2401};
  vec_t        tbl [$];
  logic        m_err, m_en, m_we;
  logic [31:0] m_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Outcome of one access from the address-map rules; applies permitted writes to ref_mem
  function automatic void model_access(input int p, input logic we, input logic [21:0] a,
                                       input logic [31:0] wd, input logic [31:0] sw,
                                       output logic err, output logic [31:0] rd,
                                       output logic en, output logic wen);
    logic is_mem, is_swb, win;
    is_mem = (a >= 22'h2000) && (a <= 22'h23FF);
    is_swb = (a == 22'h2400);
    win    = (p == 0) ? (a <= 22'h21FF) : (a >= 22'h2200);
    en     = is_mem && (!we || win);
    wen    = en && we;
    err    = !(en || (is_swb && !we));
    rd     = 32'd0;
    if (!we && is_mem) rd = ref_mem[a[9:0]];
    else if (!we && is_swb) rd = sw;
    if (wen) ref_mem[a[9:0]] = wd;
  endfunction

  function automatic vec_t mk(input bit p, input bit we, input logic [21:0] a, input logic [31:0] wd,
                              input logic [31:0] sw, input bit e_err, input logic [31:0] e_rd,
                              input bit e_en, input bit e_we);
    vec_t v;
    v.p = p; v.we = we; v.a = a; v.wd = wd; v.sw = sw;
    v.e_err = e_err; v.e_rd = e_rd; v.e_en = e_en; v.e_we = e_we;
    return v;
  endfunction

  // One isolated access on one port, checked against constant expectations
  task automatic run_one(input vec_t v, input string tag);
    int n;
    bit got;
    logic t_err, t_en, t_we;
    logic [31:0] t_rd;
    @(negedge clk);
    sw_info = v.sw;
    we_v[v.p] = v.we; addr_v[v.p] = v.a; wd_v[v.p] = v.wd; req_v[v.p] = 1'b1;
    model_access(int'(v.p), v.we, v.a, v.wd, v.sw, t_err, t_rd, t_en, t_we);
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, " mem_en"}, 32'(mem_en), 32'(v.e_en));
        chk({tag, " mem_we"}, 32'(mem_we), 32'(v.e_we));
        if (v.e_en) chk({tag, " mem_addr"}, 32'(mem_addr), 32'(v.a[9:0]));
        if (v.e_we) chk({tag, " mem_wdata"}, mem_wdata, v.wd);
      end
      got = ack_v[v.p];
    end
    req_v[v.p] = 1'b0;
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL %s ack: none within 10 cycles, required at cycle 3", tag);
    end else begin
      chk({tag, " ack latency"}, 32'(n), 32'd3);
      chk({tag, " err"}, 32'(err_v[v.p]), 32'(v.e_err));
      chk({tag, " read_data"}, rd_v[v.p], v.e_rd);
      chk({tag, " other ack"}, 32'(ack_v[!v.p]), 32'd0);
      exp_rd[v.p] = v.e_rd;
      if (v.e_err && exp_viol[v.p] != 16'hFFFF) exp_viol[v.p] = exp_viol[v.p] + 16'd1;
      @(negedge clk);
      chk({tag, " A_viol_cnt"}, 32'(viol_v[0]), 32'(exp_viol[0]));
      chk({tag, " B_viol_cnt"}, 32'(viol_v[1]), 32'(exp_viol[1]));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("%s ack%0d", tag, p), 32'(ack_v[p]), 32'd0);
      chk($sformatf("%s err%0d", tag, p), 32'(err_v[p]), 32'd0);
      chk($sformatf("%s read_data%0d", tag, p), rd_v[p], 32'd0);
      chk($sformatf("%s viol%0d", tag, p), 32'(viol_v[p]), 32'd0);
    end
    chk({tag, " mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int who, n, q, last_t, k;
    bit seen;
    logic [31:0] sw_rnd;

    rst = 1'b1; mem_init = 1'b1; sw_info = 32'd0;
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = 22'd0; wd_v[p] = 32'd0;
      exp_rd[p] = 32'd0; exp_viol[p] = 16'd0; pend[p] = 1'b0; craise[p] = 0;
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_pat(i);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0; mem_init = 1'b0;

    // ---------------- directed vector table ----------------
    //                p  we addr        wdata          sw             err rd              en we
    tbl.push_back(mk(0, 0, 22'h2005,   32'h0,         32'h0,         0, 32'h1234_5678, 1, 0));
    tbl.push_back(mk(1, 1, 22'h2010,   32'hDEAD_BEEF, 32'h0,         1, 32'h0,         0, 0));
    tbl.push_back(mk(0, 0, 22'h2010,   32'h0,         32'h0,         0, init_pat(16),  1, 0));
    tbl.push_back(mk(0, 0, 22'h2400,   32'h0,         32'hAB,        0, 32'h0000_00AB, 0, 0));
    tbl.push_back(mk(1, 1, 22'h2400,   32'h1,         32'hAB,        1, 32'h0,         0, 0));
    tbl.push_back(mk(0, 0, 22'h3000,   32'h0,         32'hAB,        1, 32'h0,         0, 0));
    tbl.push_back(mk(0, 1, 22'h2100,   32'hCAFE_0001, 32'h0,         0, 32'h0,         1, 1));
    tbl.push_back(mk(1, 0, 22'h2100,   32'h0,         32'h0,         0, 32'hCAFE_0001, 1, 0));
    tbl.push_back(mk(1, 1, 22'h23FF,   32'h55AA_55AA, 32'h0,         0, 32'h0,         1, 1));
    tbl.push_back(mk(0, 1, 22'h2200,   32'h1111_1111, 32'h0,         1, 32'h0,         0, 0));
    tbl.push_back(mk(0, 0, 22'h23FF,   32'h0,         32'h0,         0, 32'h55AA_55AA, 1, 0));
    tbl.push_back(mk(1, 1, 22'h21FF,   32'h2222_2222, 32'h0,         1, 32'h0,         0, 0));
    tbl.push_back(mk(0, 0, 22'h1FFF,   32'h0,         32'h0,         1, 32'h0,         0, 0));
    tbl.push_back(mk(0, 1, 22'h21FF,   32'h0BAD_F00D, 32'h0,         0, 32'h0,         1, 1));
    tbl.push_back(mk(1, 0, 22'h2401,   32'h0,         32'h0,         1, 32'h0,         0, 0));
    tbl.push_back(mk(1, 0, 22'h21FF,   32'h0,         32'h0,         0, 32'h0BAD_F00D, 1, 0));
    tbl.push_back(mk(0, 0, 22'h30_2005, 32'h0,        32'h0,         1, 32'h0,         0, 0));
    tbl.push_back(mk(1, 0, 22'h2000,   32'h0,         32'h0,         0, init_pat(0),   1, 0));
    tbl.push_back(mk(1, 0, 22'h2400,   32'h0,         32'hFEDC_1234, 0, 32'hFEDC_1234, 0, 0));
    foreach (tbl[i]) run_one(tbl[i], $sformatf("vec%0d", i));

    // ---------------- reset during CAPTURE of an A write ----------------
    @(negedge clk);
    we_v[0] = 1'b1; addr_v[0] = 22'h2001; wd_v[0] = 32'h7777_7777; req_v[0] = 1'b1;
    @(negedge clk);
    chk("rstmid strobe mem_we", 32'(mem_we), 32'd1);
    ref_mem[1] = 32'h7777_7777;
    @(negedge clk);
    rst = 1'b1; req_v[0] = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rstmid");
    rst = 1'b0;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0; exp_viol[0] = 16'd0; exp_viol[1] = 16'd0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack_v[0] || ack_v[1]) seen = 1'b1;
    end
    chk("rstmid no late ack", 32'(seen), 32'd0);

    // ---------------- tie after reset, then alternation ----------------
    @(negedge clk);
    we_v[0] = 1'b0; addr_v[0] = 22'h2005; we_v[1] = 1'b0; addr_v[1] = 22'h2300;
    req_v[0] = 1'b1; req_v[1] = 1'b1;
    last_t = 0;
    for (k = 0; k < 4; k++) begin
      who = -1; n = 0;
      while (who < 0 && n < 12) begin
        @(negedge clk);
        n++;
        if (ack_v[0]) who = 0;
        else if (ack_v[1]) who = 1;
      end
      if (who < 0) begin
        n_cmp++; n_fail++;
        $display("FAIL tie grant%0d: no ack within 12 cycles", k);
        break;
      end
      chk($sformatf("tie grant%0d owner", k), 32'(who), 32'(k % 2));
      if (k > 0) chk($sformatf("tie grant%0d spacing", k), 32'(cyc - last_t), 32'd4);
      last_t = cyc;
      model_access(who, 1'b0, addr_v[who], 32'd0, sw_info, m_err, m_rd, m_en, m_we);
      chk($sformatf("tie grant%0d read_data", k), rd_v[who], m_rd);
      exp_rd[who] = m_rd;
      req_v[who] = 1'b0;
      if (k < 3) begin
        @(negedge clk);
        req_v[who] = 1'b1;
      end
    end
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    model_last = 1;

    // ---------------- randomized two-port traffic ----------------
    sw_rnd = $urandom;
    sw_info = sw_rnd;
    for (int i = 0; i < 3020; i++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) chk($sformatf("rnd viol%0d", p), 32'(viol_v[p]), 32'(exp_viol[p]));
      for (int p = 0; p < 2; p++) begin
        q = 1 - p;
        if (ack_v[p]) begin
          if (!pend[p]) begin
            n_cmp++; n_fail++;
            $display("FAIL rnd ack%0d: ack with no request outstanding at cycle %0d", p, cyc);
          end else begin
            model_access(p, we_v[p], addr_v[p], wd_v[p], sw_rnd, m_err, m_rd, m_en, m_we);
            chk($sformatf("rnd err%0d a=%h", p, addr_v[p]), 32'(err_v[p]), 32'(m_err));
            chk($sformatf("rnd read_data%0d a=%h", p, addr_v[p]), rd_v[p], m_rd);
            chk($sformatf("rnd held read_data%0d", q), rd_v[q], exp_rd[q]);
            chk($sformatf("rnd min latency%0d", p), 32'(cyc - craise[p] >= 3), 32'd1);
            if (pend[q] && craise[q] <= cyc - 3)
              chk($sformatf("rnd rr winner at cycle %0d", cyc), 32'(p), 32'(1 - model_last));
            model_last = p;
            exp_rd[p] = m_rd;
            if (m_err && exp_viol[p] != 16'hFFFF) exp_viol[p] = exp_viol[p] + 16'd1;
            pend[p] = 1'b0;
            req_v[p] = 1'b0;
          end
        end else if (pend[p] && (cyc - craise[p] > 12)) begin
          n_cmp++; n_fail++;
          $display("FAIL rnd timeout%0d: no ack 12 cycles after request", p);
          pend[p] = 1'b0;
          req_v[p] = 1'b0;
        end else if (!pend[p] && i < 3000 && $urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, 9);
          if (k <= 6)      addr_v[p] = 22'h2000 + 22'($urandom_range(0, 1023));
          else if (k == 7) addr_v[p] = 22'h2400;
          else if (k == 8) addr_v[p] = 22'($urandom);
          else             addr_v[p] = edge_addr[$urandom_range(0, 5)];
          we_v[p] = 1'($urandom);
          wd_v[p] = $urandom;
          req_v[p] = 1'b1;
          pend[p] = 1'b1;
          craise[p] = cyc;
        end
      end
    end
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- violation counter saturation ----------------
    force dut.r_a_viol = 16'hFFFE;
    @(negedge clk);
    release dut.r_a_viol;
    exp_viol[0] = 16'hFFFE;
    chk("sat preset A_viol_cnt", 32'(viol_v[0]), 32'h0000_FFFE);
    run_one(mk(0, 1, 22'h2300, 32'h1, 32'h0, 1, 32'h0, 0, 0), "sat0");
    run_one(mk(0, 1, 22'h2400, 32'h2, 32'h0, 1, 32'h0, 0, 0), "sat1");
    run_one(mk(0, 1, 22'h0000, 32'h3, 32'h0, 1, 32'h0, 0, 0), "sat2");
    chk("sat final A_viol_cnt", 32'(viol_v[0]), 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
